lfsr_rand_server: RTL and testbench
===================================

Name: lfsr_rand_server

Overview:
Sits directly downstream of the 8-bit LFSR. Samples its q output, range-limits each sample by rejection, and buffers accepted values in a small FIFO for a consumer (CPU peripheral read path).
Also drives the LFSR load/SEED inputs. It applies software seeds and recovers automatically from the all-zero lockup state, so the LFSR never sits stuck at 8'h00.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
SAMPLE_DIV, 8, clocks between LFSR samples (>=1; 8 = full byte of fresh shift bits)
LOAD_CYCLES, 2, cycles lfsr_load is held high per reseed (>=1)
FALLBACK_SEED, 8'hA5, seed used on lockup or when software writes 8'h00

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
lfsr_q  in  8  current LFSR state
lfsr_load  out  1  load strobe to LFSR
lfsr_seed  out  8  seed value to LFSR SEED input
seed_in  in  8  software seed
seed_wr  in  1  one-cycle pulse: reseed with seed_in
limit  in  8  exclusive upper bound; 0 = full range 0..255
rd_req  in  1  pop request; ignored when rand_vld=0
rand_vld  out  1  FIFO non-empty
rand_data  out  8  FIFO head (valid when rand_vld=1)
full  out  1  FIFO full

Behaviour:
- Reset values: lfsr_load=0, lfsr_seed=FALLBACK_SEED, rand_vld=0, full=0, rand_data=0. FIFO is empty, sample counter is 0, FSM is in LOAD.
- After reset the block performs one reseed with FALLBACK_SEED before any sampling.
- FSM states: LOAD -> SETTLE -> RUN.
  - LOAD: lfsr_load=1 for exactly LOAD_CYCLES clocks, with lfsr_seed held stable. Then go to SETTLE.
  - SETTLE: 1 clock with lfsr_load=0 and no sampling. Sample counter is cleared. Then go to RUN.
  - RUN: sample counter counts 0..SAMPLE_DIV-1. A sample of lfsr_q is taken in the cycle the counter equals SAMPLE_DIV-1.
- Lockup: a RUN sample equal to 8'h00 is discarded. lfsr_seed <= FALLBACK_SEED, FSM -> LOAD. The FIFO is kept.
- seed_wr:
  - Accepted in any state, and restarts LOAD even mid-LOAD.
  - lfsr_seed <= (seed_in==0 ? FALLBACK_SEED : seed_in). FIFO is flushed the same edge. Any pending sample is dropped.
  - seed_wr has priority over lockup and over rd_req; the pop is lost.
- Range: mask = smallest (2^k - 1) >= limit-1, with mask=8'hFF when limit=0 and mask=0 when limit=1. m = sample & mask.
  - Accept when limit==0 or m < limit. Accepted m is pushed. Rejected samples are dropped silently.
  - limit is sampled combinationally at the sample cycle. A change between samples needs no flush.
- FIFO:
  - Push on accepted sample when not full; a sample arriving while full is dropped.
  - Pop on rd_req & rand_vld. Simultaneous push and pop when full: both happen and occupancy is unchanged.
  - Read/write pointers wrap modulo DEPTH, with an extra bit for the full/empty test.
  - rand_data is the registered head, updated the cycle after a pop or after the first push into an empty FIFO.
  - rand_vld rises 1 clock after the accepting sample.
  - full = occupancy==DEPTH, registered.
- The LFSR itself is never advanced or reset by this block, only loaded.

Decomposition:
- Package lfsr_pkg:
  - state typedef enum {LOAD, SETTLE, RUN}
  - FALLBACK_SEED default constant
  - function range_mask(limit) returning the 8-bit mask
- One sub-module, rand_fifo: DEPTH x 8 synchronous FIFO with push/pop/flush, vld/full, registered head.
- FSM, sample counter and range logic live in the top.

Test Plan:
- Reset release with lfsr_q driven 8'h3C, limit=0: lfsr_load high exactly 2 cycles with lfsr_seed=8'hA5. First push after SETTLE + SAMPLE_DIV clocks. rand_data=8'h3C, rand_vld 1 clock later.
- limit=10, bench drives samples 8'h27, 8'h2E, 8'h05: mask=8'h0F. 8'h27->7 pushed, 8'h2E->14 rejected, 8'h05->5 pushed. FIFO holds 7,5.
- No rd_req, 6 accepted samples: full=1 after 4 pushes, 5th/6th dropped. Pops return the first 4 in order. Simultaneous push/pop at full keeps full=1.
- Drive lfsr_q=8'h00 in RUN: no push. Relaunch LOAD for 2 cycles with seed 8'hA5. FIFO contents preserved.
- seed_wr with seed_in=8'h12 while FIFO holds 3 entries and rd_req=1: FIFO empties, no pop recorded, lfsr_seed=8'h12. Repeat with seed_in=8'h00 -> lfsr_seed=8'hA5.
- Assert rst_n=0 mid-LOAD and mid-RUN: outputs go to reset values immediately (async). After release, a full LOAD(2)+SETTLE(1) sequence repeats.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR random-number server: FSM state
// encoding, default fallback seed and the rejection-sampling range mask.
package lfsr_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2
   } state_e;

   localparam logic [7:0] FALLBACK_SEED_DEF = 8'hA5;

   // Smallest all-ones mask covering limit-1; limit 0 means full byte range.
   function automatic logic [7:0] range_mask(input logic [7:0] limit);
      logic [7:0] v;
      if (limit == 8'd0) begin
         v = 8'hFF;
      end else begin
         v = limit - 8'd1;
         v = v | (v >> 1);
         v = v | (v >> 2);
         v = v | (v >> 4);
      end
      return v;
   endfunction

endpackage

// File: rtl/rand_fifo.sv
// DEPTH x 8 synchronous FIFO with flush, registered head value, and
// registered valid/full flags derived from the next-state pointers.
module rand_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush_i,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   input  logic       pop_i,
   output logic       vld_o,
   output logic       full_o,
   output logic [7:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   logic [7:0]  head_q, head_d;
   logic        vld_q, vld_d;
   logic        full_q, full_d;
   logic        do_push;
   logic        do_pop;

   always_comb begin
      do_pop  = pop_i & vld_q;
      // A full FIFO still accepts a push when a pop frees a slot the same edge.
      do_push = push_i & (~full_q | do_pop);
      wr_d    = wr_q + {{AW{1'b0}}, do_push};
      rd_d    = rd_q + {{AW{1'b0}}, do_pop};
      head_d  = head_q;
      if (flush_i) begin
         wr_d   = '0;
         rd_d   = '0;
         head_d = 8'h00;
      end else if (wr_d != rd_d) begin
         if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
            head_d = push_data_i;
         end else begin
            head_d = mem_q[rd_d[AW-1:0]];
         end
      end
      vld_d  = (wr_d != rd_d);
      full_d = ((wr_d - rd_d) == (AW+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wr_q[AW-1:0]] <= push_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         head_q <= 8'h00;
         vld_q  <= 1'b0;
         full_q <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         head_q <= head_d;
         vld_q  <= vld_d;
         full_q <= full_d;
      end
   end

   assign vld_o  = vld_q;
   assign full_o = full_q;
   assign head_o = head_q;

endmodule

// File: rtl/lfsr_rand_server.sv
// Samples an external 8-bit LFSR, range-limits samples by rejection and
// buffers accepted values; also seeds the LFSR and recovers from lockup.
module lfsr_rand_server
   import lfsr_pkg::*;
#(
   parameter int         DEPTH         = 4,
   parameter int         SAMPLE_DIV    = 8,
   parameter int         LOAD_CYCLES   = 2,
   parameter logic [7:0] FALLBACK_SEED = FALLBACK_SEED_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] lfsr_q,
   output logic       lfsr_load,
   output logic [7:0] lfsr_seed,
   input  logic [7:0] seed_in,
   input  logic       seed_wr,
   input  logic [7:0] limit,
   input  logic       rd_req,
   output logic       rand_vld,
   output logic [7:0] rand_data,
   output logic       full
);

   localparam int LCW = $clog2(LOAD_CYCLES + 1);
   localparam int CW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   state_e         state_q, state_d;
   logic           load_q, load_d;
   logic [LCW-1:0] lcnt_q, lcnt_d;
   logic [CW-1:0]  scnt_q, scnt_d;
   logic [7:0]     seed_q, seed_d;
   logic [7:0]     mask;
   logic [7:0]     masked;
   logic           sample_fire;
   logic           push;

   always_comb begin
      state_d     = state_q;
      load_d      = load_q;
      lcnt_d      = lcnt_q;
      scnt_d      = scnt_q;
      seed_d      = seed_q;
      push        = 1'b0;
      mask        = range_mask(limit);
      masked      = lfsr_q & mask;
      sample_fire = (state_q == RUN) && (scnt_q == CW'(SAMPLE_DIV - 1));

      case (state_q)
         // Out of reset lcnt starts at 0, giving one idle cycle before the strobe.
         LOAD: begin
            if (lcnt_q == LCW'(LOAD_CYCLES)) begin
               load_d  = 1'b0;
               state_d = SETTLE;
            end else begin
               load_d = 1'b1;
               lcnt_d = lcnt_q + LCW'(1);
            end
         end
         SETTLE: begin
            scnt_d  = '0;
            state_d = RUN;
         end
         RUN: begin
            if (sample_fire) begin
               scnt_d = '0;
               if (lfsr_q == 8'h00) begin
                  seed_d  = FALLBACK_SEED;
                  state_d = LOAD;
                  load_d  = 1'b1;
                  lcnt_d  = LCW'(1);
               end else if ((limit == 8'd0) || (masked < limit)) begin
                  push = 1'b1;
               end
            end else begin
               scnt_d = scnt_q + CW'(1);
            end
         end
         default: begin
            state_d = LOAD;
            load_d  = 1'b0;
            lcnt_d  = '0;
         end
      endcase

      // Software reseed overrides lockup recovery, sampling and reads.
      if (seed_wr) begin
         seed_d  = (seed_in == 8'h00) ? FALLBACK_SEED : seed_in;
         state_d = LOAD;
         load_d  = 1'b1;
         lcnt_d  = LCW'(1);
         push    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         load_q  <= 1'b0;
         lcnt_q  <= '0;
         scnt_q  <= '0;
         seed_q  <= FALLBACK_SEED;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         lcnt_q  <= lcnt_d;
         scnt_q  <= scnt_d;
         seed_q  <= seed_d;
      end
   end

   assign lfsr_load = load_q;
   assign lfsr_seed = seed_q;

   rand_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (seed_wr),
      .push_i      (push),
      .push_data_i (masked),
      .pop_i       (rd_req),
      .vld_o       (rand_vld),
      .full_o      (full),
      .head_o      (rand_data)
   );

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Directed bench for lfsr_rand_server: the bench plays the LFSR, predicts
// accepted samples into an expected queue and checks the FIFO outputs.
module tb_lfsr_rand_server;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] lfsr_q;
   logic       lfsr_load;
   logic [7:0] lfsr_seed;
   logic [7:0] seed_in;
   logic       seed_wr;
   logic [7:0] limit;
   logic       rd_req;
   logic       rand_vld;
   logic [7:0] rand_data;
   logic       full;

   int checks;
   int errors;
   int cyc;
   int next_samp;
   logic [7:0] exp_q[$];

   lfsr_rand_server #(
      .DEPTH         (DEPTH),
      .SAMPLE_DIV    (8),
      .LOAD_CYCLES   (2),
      .FALLBACK_SEED (8'hA5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lfsr_q    (lfsr_q),
      .lfsr_load (lfsr_load),
      .lfsr_seed (lfsr_seed),
      .seed_in   (seed_in),
      .seed_wr   (seed_wr),
      .limit     (limit),
      .rd_req    (rd_req),
      .rand_vld  (rand_vld),
      .rand_data (rand_data),
      .full      (full)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_mask(input int lim);
      int mk;
      if (lim == 0) return 255;
      mk = 0;
      while (mk < lim - 1) mk = mk * 2 + 1;
      return mk;
   endfunction

   task automatic check_fifo(input string tag);
      check({tag, "_vld"}, 32'(rand_vld), 32'(exp_q.size() != 0));
      check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
      if (exp_q.size() != 0) check({tag, "_data"}, 32'(rand_data), 32'(exp_q[0]));
   endtask

   // Idle inputs: limit 3 with sample FF masks to 3, which is always rejected.
   task automatic set_idle();
      lfsr_q = 8'hFF;
      limit  = 8'd3;
   endtask

   // ---------------- driver tasks ----------------
   task automatic sync_load(input logic [7:0] seed);
      int n;
      int hi;
      n = 0;
      while (lfsr_load !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("load_rise", 32'(lfsr_load), 32'd1);
      hi = 0;
      while (lfsr_load === 1'b1 && hi < 40) begin
         check("load_seed", 32'(lfsr_seed), 32'(seed));
         hi++;
         @(negedge clk);
      end
      check("load_cycles", 32'(hi), 32'd2);
      next_samp = cyc + 9;
   endtask

   task automatic do_sample(input logic [7:0] v, input logic [7:0] lim);
      int mk;
      int m;
      while (next_samp <= cyc) next_samp += 8;
      lfsr_q = v;
      limit  = lim;
      while (cyc < next_samp - 1) @(negedge clk);
      check_fifo("pre_sample");
      @(negedge clk);
      if (v != 8'h00) begin
         mk = model_mask(int'(lim));
         m  = int'(v) & mk;
         if ((lim == 8'd0 || m < int'(lim)) && exp_q.size() < DEPTH) exp_q.push_back(8'(m));
      end
      set_idle();
      next_samp += 8;
      check_fifo("post_sample");
   endtask

   task automatic do_pop();
      check_fifo("pre_pop");
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      check_fifo("post_pop");
   endtask

   task automatic push_pop_full(input logic [7:0] v);
      while (next_samp <= cyc) next_samp += 8;
      lfsr_q = v;
      limit  = 8'd0;
      while (cyc < next_samp - 1) @(negedge clk);
      check_fifo("pp_pre");
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(v);
      set_idle();
      next_samp += 8;
      check_fifo("pp_post");
   endtask

   task automatic seed_write(input logic [7:0] s, input logic [7:0] exp_seed);
      seed_in = s;
      seed_wr = 1'b1;
      rd_req  = 1'b1;
      @(negedge clk);
      seed_wr = 1'b0;
      rd_req  = 1'b0;
      exp_q.delete();
      check_fifo("seed_flush");
      check("seed_value", 32'(lfsr_seed), 32'(exp_seed));
      sync_load(exp_seed);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_load"}, 32'(lfsr_load), 32'd0);
      check({tag, "_seed"}, 32'(lfsr_seed), 32'hA5);
      check({tag, "_vld"}, 32'(rand_vld), 32'd0);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_data"}, 32'(rand_data), 32'd0);
   endtask

   task automatic async_reset(input string tag);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values(tag);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      seed_in = 8'h00;
      seed_wr = 1'b0;
      rd_req  = 1'b0;
      lfsr_q  = 8'h3C;
      limit   = 8'd0;
      next_samp = 0;
      @(negedge clk);
      @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      // Power-up reseed, then the first sample passes straight through.
      sync_load(8'hA5);
      do_sample(8'h3C, 8'd0);
      do_pop();

      // Rejection sampling with limit 10 (mask 0F).
      do_sample(8'h27, 8'd10);
      do_sample(8'h2E, 8'd10);
      do_sample(8'h05, 8'd10);
      check("lim_depth", 32'(exp_q.size()), 32'd2);
      do_pop();
      do_pop();

      // Fill past DEPTH; overflow samples are dropped.
      do_sample(8'h11, 8'd0);
      do_sample(8'h22, 8'd0);
      do_sample(8'h33, 8'd0);
      do_sample(8'h44, 8'd0);
      do_sample(8'h55, 8'd0);
      do_sample(8'h66, 8'd0);
      push_pop_full(8'h77);
      do_pop();
      do_pop();
      do_pop();
      do_pop();

      // Read request on an empty FIFO is ignored.
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      check_fifo("empty_pop");

      // Lockup: an all-zero sample triggers a fallback reseed, FIFO kept.
      do_sample(8'h81, 8'd0);
      do_sample(8'h42, 8'd0);
      do_sample(8'h00, 8'd0);
      sync_load(8'hA5);
      check_fifo("lockup_keep");
      do_sample(8'h99, 8'd0);
      check("three_held", 32'(exp_q.size()), 32'd3);

      // Software reseed flushes the FIFO and drops the coincident pop.
      seed_write(8'h12, 8'h12);
      seed_write(8'h00, 8'hA5);
      do_sample(8'h5A, 8'd0);

      // Asynchronous reset in RUN, then in LOAD.
      async_reset("rst_run");
      sync_load(8'hA5);
      do_sample(8'h3C, 8'd0);
      seed_in = 8'h34;
      seed_wr = 1'b1;
      @(negedge clk);
      seed_wr = 1'b0;
      check("mid_load", 32'(lfsr_load), 32'd1);
      async_reset("rst_load");
      sync_load(8'hA5);
      do_sample(8'hC3, 8'd10);
      do_pop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
